// File: rtl/muldiv_pkg.sv
// Shared types and sizing helpers for the iterative multiply/divide sequencer.
package muldiv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef enum logic {
        OP_MULT,
        OP_DIV
    } op_t;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned CNT_W      = $clog2(DEF_DATA_W);

    // Iteration counter width for an arbitrary operand width (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/muldiv_sequencer_if.sv
// Execute-stage <-> multiply/divide sequencer bundle.
// The is_signed signal exists only when MULDIV_SIGNED_EN is defined.
interface muldiv_sequencer_if #(
    parameter int unsigned DATA_W = 32
);
    logic              start_mult;
    logic              start_div;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic              mfhi_req;
    logic              mflo_req;
    logic              mthi_req;
    logic              mtlo_req;
`ifdef MULDIV_SIGNED_EN
    logic              is_signed;
`endif
    logic [DATA_W-1:0] rd_data;
    logic              busy_o;
    logic              stall_o;
    logic [DATA_W-1:0] hi_o;
    logic [DATA_W-1:0] lo_o;

    modport master (
        output start_mult, start_div, op_a, op_b, mfhi_req, mflo_req, mthi_req, mtlo_req,
`ifdef MULDIV_SIGNED_EN
        output is_signed,
`endif
        input  rd_data, busy_o, stall_o, hi_o, lo_o
    );

    modport slave (
        input  start_mult, start_div, op_a, op_b, mfhi_req, mflo_req, mthi_req, mtlo_req,
`ifdef MULDIV_SIGNED_EN
        input  is_signed,
`endif
        output rd_data, busy_o, stall_o, hi_o, lo_o
    );

endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  op_t               op,
    input  logic [DATA_W:0]   acc_hi,
    input  logic [DATA_W-1:0] acc_lo,
    input  logic [DATA_W-1:0] operand,
    output logic [DATA_W:0]   nxt_hi,
    output logic [DATA_W-1:0] nxt_lo
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   shifted;
    logic [DATA_W+1:0] diff;

    always_comb begin
        // Multiply: {acc_hi, acc_lo} is the product accumulator, multiplier sits in acc_lo.
        sum     = acc_hi + (acc_lo[0] ? {1'b0, operand} : '0);
        // Divide: acc_hi is the partial remainder, acc_lo shifts dividend out / quotient in.
        shifted = {acc_hi[DATA_W-1:0], acc_lo[DATA_W-1]};
        diff    = {1'b0, shifted} - {2'b00, operand};
        nxt_hi  = '0;
        nxt_lo  = '0;
        if (op == OP_MULT) begin
            nxt_hi = {1'b0, sum[DATA_W:1]};
            nxt_lo = {sum[0], acc_lo[DATA_W-1:1]};
        end else if (diff[DATA_W+1]) begin
            nxt_hi = shifted;
            nxt_lo = {acc_lo[DATA_W-2:0], 1'b0};
        end else begin
            nxt_hi = diff[DATA_W:0];
            nxt_lo = {acc_lo[DATA_W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide controller owning HI/LO; stalls execute while an op is in flight.
// Optional MULDIV_SIGNED_EN adds signed operation selected by bus.is_signed.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    muldiv_sequencer_if.slave bus
);

    localparam int unsigned            CNT_BITS = cnt_width(DATA_W);
    localparam logic [CNT_BITS-1:0]    LAST     = CNT_BITS'(DATA_W - 1);

    state_t              state;
    op_t                 op_q;
    logic [CNT_BITS-1:0] count;
    logic [DATA_W:0]     acc_hi;
    logic [DATA_W-1:0]   acc_lo;
    logic [DATA_W-1:0]   operand;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                busy_q;

    logic [DATA_W:0]     nxt_hi;
    logic [DATA_W-1:0]   nxt_lo;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   fin_hi;
    logic [DATA_W-1:0]   fin_lo;
    logic                start_any;

`ifdef MULDIV_SIGNED_EN
    logic                neg_a;
    logic                neg_b;
    logic                neg_res_q;
    logic                neg_rem_q;
    logic [2*DATA_W-1:0] prod_neg;

    assign neg_a = bus.is_signed & bus.op_a[DATA_W-1];
    assign neg_b = bus.is_signed & bus.op_b[DATA_W-1];
    assign mag_a = neg_a ? -bus.op_a : bus.op_a;
    assign mag_b = neg_b ? -bus.op_b : bus.op_b;
`else
    assign mag_a = bus.op_a;
    assign mag_b = bus.op_b;
`endif

    assign start_any = bus.start_mult | bus.start_div;

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .op      (op_q),
        .acc_hi  (acc_hi),
        .acc_lo  (acc_lo),
        .operand (operand),
        .nxt_hi  (nxt_hi),
        .nxt_lo  (nxt_lo)
    );

    // Magnitude result from the iterations; signs are only reapplied when committing.
    always_comb begin
        fin_hi = acc_hi[DATA_W-1:0];
        fin_lo = acc_lo;
`ifdef MULDIV_SIGNED_EN
        prod_neg = -{acc_hi[DATA_W-1:0], acc_lo};
        if (op_q == OP_MULT) begin
            if (neg_res_q) {fin_hi, fin_lo} = prod_neg;
        end else begin
            if (neg_res_q) fin_lo = -acc_lo;
            if (neg_rem_q) fin_hi = -acc_hi[DATA_W-1:0];
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= OP_MULT;
            count   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            operand <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
`ifdef MULDIV_SIGNED_EN
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_any) begin
                        // Multiply wins when both starts arrive together.
                        op_q    <= bus.start_mult ? OP_MULT : OP_DIV;
                        count   <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= bus.start_mult ? mag_b : mag_a;
                        operand <= bus.start_mult ? mag_a : mag_b;
                        busy_q  <= 1'b1;
                        state   <= RUN;
`ifdef MULDIV_SIGNED_EN
                        neg_res_q <= neg_a ^ neg_b;
                        neg_rem_q <= neg_a;
`endif
                    end else begin
                        if (bus.mthi_req) hi_q <= bus.op_a;
                        if (bus.mtlo_req) lo_q <= bus.op_a;
                    end
                end
                RUN: begin
                    acc_hi <= nxt_hi;
                    acc_lo <= nxt_lo;
                    count  <= count + CNT_BITS'(1);
                    if (count == LAST) state <= DONE;
                end
                DONE: begin
                    hi_q   <= fin_hi;
                    lo_q   <= fin_lo;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy_o  = busy_q;
    assign bus.hi_o    = hi_q;
    assign bus.lo_o    = lo_q;
    assign bus.stall_o = busy_q & (start_any | bus.mfhi_req | bus.mflo_req |
                                   bus.mthi_req | bus.mtlo_req);
    assign bus.rd_data = bus.mfhi_req ? hi_q : (bus.mflo_req ? lo_q : '0);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: stimulus queues expected HI/LO, monitor checks on completion.
module tb_muldiv_sequencer;

    localparam int unsigned W = 32;

    logic clock = 1'b0;
    logic reset;

    muldiv_sequencer_if #(.DATA_W(W)) bus ();

    muldiv_sequencer #(.DATA_W(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned   t0;
        int unsigned   id;
        logic [W-1:0]  hi;
        logic [W-1:0]  lo;
    } exp_t;

    exp_t        sb[$];
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned failures = 0;
    bit          abort = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a falling busy_o (outside an aborting reset) is a completed operation.
    initial begin : monitor
        logic busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (busy_prev === 1'b1 && bus.busy_o === 1'b0 && !abort) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: completion with empty scoreboard (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check($sformatf("op%0d_latency", e.id), 64'(cyc), 64'(e.t0 + 34));
                    check($sformatf("op%0d_hi", e.id), 64'(bus.hi_o), 64'(e.hi));
                    check($sformatf("op%0d_lo", e.id), 64'(bus.lo_o), 64'(e.lo));
                end
            end
            busy_prev = bus.busy_o;
        end
    end

    task automatic issue(input bit m, input bit d, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ehi, input logic [W-1:0] elo, input int unsigned id,
                         output int unsigned t0);
        @(negedge clock);
        bus.start_mult = m;
        bus.start_div  = d;
        bus.op_a       = a;
        bus.op_b       = b;
        t0 = cyc;
        sb.push_back('{t0: cyc, id: id, hi: ehi, lo: elo});
        @(negedge clock);
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
    endtask

    task automatic wait_idle(input int unsigned id);
        int unsigned n;
        n = 0;
        while (bus.busy_o !== 1'b0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n >= 100) begin
            failures++;
            $display("FAIL op%0d_timeout: busy_o still 0x%0h after %0d cycles, required 0", id, bus.busy_o, n);
        end
    endtask

    initial begin : stimulus
        int unsigned t0;
        bus.start_mult = 1'b0;
        bus.start_div  = 1'b0;
        bus.op_a       = '0;
        bus.op_b       = '0;
        bus.mfhi_req   = 1'b0;
        bus.mflo_req   = 1'b0;
        bus.mthi_req   = 1'b0;
        bus.mtlo_req   = 1'b0;
`ifdef MULDIV_SIGNED_EN
        bus.is_signed  = 1'b0;
`endif
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        #1;
        check("reset_busy", 64'(bus.busy_o), 64'd0);
        check("reset_hi", 64'(bus.hi_o), 64'd0);
        check("reset_lo", 64'(bus.lo_o), 64'd0);
        check("reset_rd_data", 64'(bus.rd_data), 64'd0);
        bus.mfhi_req = 1'b1;
        #1;
        check("idle_no_stall", 64'(bus.stall_o), 64'd0);
        bus.mfhi_req = 1'b0;

        // 7*6 with busy window checks
        @(negedge clock);
        check("busy_before_start", 64'(bus.busy_o), 64'd0);
        issue(1'b1, 1'b0, 32'd7, 32'd6, 32'd0, 32'd42, 1, t0);
        check("busy_T+1", 64'(bus.busy_o), 64'd1);
        while (cyc < t0 + 33) @(negedge clock);
        check("busy_T+33", 64'(bus.busy_o), 64'd1);
        @(negedge clock);
        check("busy_T+34", 64'(bus.busy_o), 64'd0);

        issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 2, t0);
        wait_idle(2);
        issue(1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 32'd14, 3, t0);
        wait_idle(3);
        issue(1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 4, t0);
        wait_idle(4);

        // MFLO held from T+5 stalls until the result commits
        issue(1'b1, 1'b0, 32'd5, 32'd9, 32'd0, 32'd45, 5, t0);
        while (cyc < t0 + 5) @(negedge clock);
        bus.mflo_req = 1'b1;
        while (cyc <= t0 + 33) begin
            #1;
            check($sformatf("stall_c%0d", cyc - t0), 64'(bus.stall_o), 64'd1);
            @(negedge clock);
        end
        #1;
        check("stall_released", 64'(bus.stall_o), 64'd0);
        check("mflo_rd_data", 64'(bus.rd_data), 64'd45);
        bus.mflo_req = 1'b0;

        // Reset mid-operation at iteration 10
        issue(1'b1, 1'b0, 32'h1234, 32'h10, 32'd0, 32'd0, 6, t0);
        while (cyc < t0 + 11) @(negedge clock);
        abort = 1'b1;
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        void'(sb.pop_back());
        #1;
        check("abort_busy", 64'(bus.busy_o), 64'd0);
        check("abort_hi", 64'(bus.hi_o), 64'd0);
        check("abort_lo", 64'(bus.lo_o), 64'd0);
        @(negedge clock);
        abort = 1'b0;
        issue(1'b1, 1'b0, 32'd3, 32'd5, 32'd0, 32'd15, 7, t0);
        wait_idle(7);

        // Both starts: multiply wins (3/4 would give lo=0, hi=3)
        issue(1'b1, 1'b1, 32'd3, 32'd4, 32'd0, 32'd12, 8, t0);
        wait_idle(8);

        // MTHI / MTLO in IDLE, then MFHI readback
        @(negedge clock);
        bus.mthi_req = 1'b1;
        bus.op_a     = 32'h55;
        @(negedge clock);
        bus.mthi_req = 1'b0;
        bus.mtlo_req = 1'b1;
        bus.op_a     = 32'hAA;
        #1;
        check("mthi_hi", 64'(bus.hi_o), 64'h55);
        @(negedge clock);
        bus.mtlo_req = 1'b0;
        bus.mfhi_req = 1'b1;
        #1;
        check("mtlo_lo", 64'(bus.lo_o), 64'hAA);
        check("mfhi_rd_data", 64'(bus.rd_data), 64'h55);
        bus.mfhi_req = 1'b0;

        // MTHI with a start in the same cycle: the start wins, HI untouched
        @(negedge clock);
        bus.mthi_req   = 1'b1;
        bus.start_mult = 1'b1;
        bus.op_a       = 32'h77;
        bus.op_b       = 32'd1;
        sb.push_back('{t0: cyc, id: 9, hi: 32'd0, lo: 32'h77});
        @(negedge clock);
        bus.mthi_req   = 1'b0;
        bus.start_mult = 1'b0;
        #1;
        check("mthi_lost_to_start", 64'(bus.hi_o), 64'h55);
        wait_idle(9);

`ifdef MULDIV_SIGNED_EN
        bus.is_signed = 1'b1;
        issue(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, t0);
        wait_idle(10);
        issue(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 11, t0);
        wait_idle(11);
        bus.is_signed = 1'b0;
`endif

        repeat (3) @(negedge clock);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
